hc595_tx: RTL and testbench
===========================

HC595_TX -- requirements
Module: hc595_tx

Interface
REQ-001 SHALL provide parameter N, default 8, serialized word width (N >= 1).
REQ-002 SHALL provide parameter CLK_DIV, default 2, clk cycles per SHCP half-period and per STCP pulse (CLK_DIV >= 1).
REQ-003 SHALL have ports:
- clk  input  1  system clock; all logic on posedge clk; single clock domain.
- rst  input  1  reset; asynchronous, active-high.
- d  input  N  parallel word to display.
- valid  input  1  d is valid.
- ready  output  1  block can accept a word.
- DS  output  1  serial data to the 595 chain.
- SHCP  output  1  shift clock to the 595 chain.
- STCP  output  1  storage/latch clock to the 595 chain.
- busy  output  1  transfer in progress; always equals ~ready.

Function
REQ-004 SHALL accept a word on the posedge where valid && ready; otherwise d SHALL be ignored.
REQ-005 SHALL capture d into an internal N-bit shift register on accept, so later changes to d have no effect.
REQ-006 SHALL implement the FSM IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LATCH) -> IDLE.
REQ-007 IDLE: ready=1, SHCP=0, STCP=0, DS holds its last value; on accept, go to SHIFT_LO with bit count = N.
REQ-008 SHIFT_LO: lasts exactly CLK_DIV cycles; SHCP=0; DS = current MSB of the shift register.
REQ-009 SHIFT_HI: lasts exactly CLK_DIV cycles; SHCP=1; DS is unchanged.
- On exit: shift left by one and decrement the count.
- If count reaches 0, go to LATCH; otherwise go to SHIFT_LO.
REQ-010 Bit order SHALL be MSB first: d[N-1] is on DS at the first SHCP rising edge, d[0] at the Nth.
REQ-011 LATCH: lasts exactly CLK_DIV cycles; STCP=1, SHCP=0; then go to IDLE.
REQ-012 Each transfer SHALL produce exactly N SHCP rising edges and exactly one STCP pulse.
REQ-013 ready SHALL be 0 from the cycle after accept for exactly (2N+1)*CLK_DIV cycles.
REQ-014 valid asserted while busy SHALL be ignored; the word is taken on the first cycle ready=1.
REQ-015 Back-to-back transfers: if valid is held, the next word SHALL be accepted on the first IDLE cycle, with no idle gap beyond that one cycle.
REQ-016 SHCP and STCP SHALL never be 1 in the same cycle.
REQ-017 DS SHALL be stable for at least CLK_DIV cycles before and during every SHCP high phase.
REQ-018 DS, SHCP, STCP and ready SHALL be driven directly from flops (glitch-free).
REQ-019 Divider and bit counters SHALL be sized to $clog2 of their ranges and SHALL NOT wrap during a transfer.

Reset
REQ-020 On rst=1 the block SHALL immediately set state=IDLE, DS=0, SHCP=0, STCP=0, ready=1, busy=0, and clear the shift register and counters.
REQ-021 Reset mid-transfer SHALL abort the transfer with no STCP pulse; the 595 storage register keeps its prior contents.
REQ-022 The first accept SHALL be possible on the first posedge after rst deasserts.

Configuration
REQ-023 Macro HC595_OE_EN SHALL, when defined, add output OE_n (1 bit, active-low output enable to the 595 chain).
- OE_n = 1 from reset until the falling edge of the first completed STCP pulse; 0 thereafter until the next reset.
- Without the macro, the OE_n port SHALL NOT exist and all other behaviour SHALL be identical.

Structure
REQ-024 hc595_pkg SHALL hold the FSM state enum typedef and the default constants for N and CLK_DIV.
REQ-025 Sub-module hc595_tick SHALL implement the CLK_DIV phase counter and emit a one-cycle phase_done strobe; the FSM SHALL advance only on that strobe.

Verification
REQ-026 N=8, CLK_DIV=2, send 8'hA5 -> DS sampled at SHCP rises = 1,0,1,0,0,1,0,1; 8 SHCP rises; one 2-cycle STCP pulse; ready low for 34 cycles.
REQ-027 N=8, CLK_DIV=1, valid held with 8'hFF then 8'h00 -> two transfers, each with ready low for 17 cycles and exactly 1 idle cycle between them; second word on DS is all zeros.
REQ-028 Change d and pulse valid during a transfer of 8'h3C -> DS sequence still 0,0,1,1,1,1,0,0; second pulse ignored.
REQ-029 Assert rst after the 4th SHCP rise of 8'hC3 -> outputs go to reset values in the same cycle; no STCP pulse; the next word 8'h81 transfers correctly.
REQ-030 HC595_OE_EN defined, send 8'h01 after reset -> OE_n=1 until the STCP pulse ends, then 0; a subsequent reset returns OE_n to 1.
REQ-031 All scenarios SHALL assert continuously that SHCP && STCP never occurs and that busy == ~ready.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared types and default constants for the 74HC595 serial transmitter.
package hc595_pkg;

  localparam int N_DEFAULT       = 8;
  localparam int CLK_DIV_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

endpackage

// File: rtl/hc595_tick.sv
// Phase timer: counts CLK_DIV cycles while enabled and strobes phase_done on
// the last cycle of each phase.
module hc595_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic          last_s;

  // Terminal count of the current phase
  always_comb begin
    if (en && (cnt_r == CW'(CLK_DIV - 1))) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  assign phase_done = last_s;

  // Counter restarts at every phase boundary and stays cleared while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!en || last_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/hc595_tx.sv
// Parallel-to-serial driver for a 74HC595 chain, MSB first, one STCP latch per word.
// Optional macro HC595_OE_EN adds an active-low OE_n output held off until the first latch.
module hc595_tx
  import hc595_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         valid,
  output logic         ready,
  output logic         DS,
  output logic         SHCP,
  output logic         STCP,
  output logic         busy
`ifdef HC595_OE_EN
  ,
  output logic         OE_n
`endif
);

  localparam int BW = $clog2(N + 1);

  state_t         state_r, state_s;
  logic [N-1:0]   shreg_r, shreg_s;
  logic [BW-1:0]  bit_cnt_r, bit_cnt_s;
  logic           tick_en_s, phase_done_s;
  logic           ds_r, ds_s;
  logic           shcp_r, shcp_s;
  logic           stcp_r, stcp_s;
  logic           ready_r, ready_s;
  logic           busy_r, busy_s;

  assign tick_en_s = (state_r != ST_IDLE);

  hc595_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (tick_en_s),
    .phase_done(phase_done_s)
  );

  // State, shift register and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      bit_cnt_r <= bit_cnt_s;
    end
  end

  // Next state; the word is captured and the bit count loaded on accept
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    bit_cnt_s = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (valid) begin
          state_s   = ST_SHIFT_LO;
          shreg_s   = d;
          bit_cnt_s = BW'(N);
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_done_s) begin
          state_s = ST_SHIFT_HI;
        end else begin
          state_s = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_done_s) begin
          shreg_s   = shreg_r << 1;
          bit_cnt_s = bit_cnt_r - BW'(1);
          if (bit_cnt_r == BW'(1)) begin
            state_s = ST_LATCH;
          end else begin
            state_s = ST_SHIFT_LO;
          end
        end else begin
          state_s = ST_SHIFT_HI;
        end
      end
      ST_LATCH: begin
        if (phase_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LATCH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins come straight off flops
  always_comb begin
    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s != ST_IDLE);
    shcp_s  = (state_s == ST_SHIFT_HI);
    stcp_s  = (state_s == ST_LATCH);
    if (state_s == ST_SHIFT_LO) begin
      ds_s = shreg_s[N-1];
    end else begin
      ds_s = ds_r;
    end
  end

  // Output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_r    <= 1'b0;
      shcp_r  <= 1'b0;
      stcp_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      ds_r    <= ds_s;
      shcp_r  <= shcp_s;
      stcp_r  <= stcp_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  assign DS    = ds_r;
  assign SHCP  = shcp_r;
  assign STCP  = stcp_r;
  assign ready = ready_r;
  assign busy  = busy_r;

`ifdef HC595_OE_EN
  logic oe_n_r;

  // Outputs stay disabled until the first latch has completed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_n_r <= 1'b1;
    end else if ((state_r == ST_LATCH) && phase_done_s) begin
      oe_n_r <= 1'b0;
    end else begin
      oe_n_r <= oe_n_r;
    end
  end

  assign OE_n = oe_n_r;
`endif

endmodule

// File: tb/tb_hc595_tx.sv
// Scoreboard bench for hc595_tx: instance A uses CLK_DIV=2, instance B uses CLK_DIV=1.
// Build with HC595_OE_EN defined to also check OE_n on instance A.
module tb_hc595_tx;

  logic       clk;
  logic       rst;
  logic [7:0] d_a, d_b;
  logic       valid_a, valid_b;
  logic       ready_a, ds_a, shcp_a, stcp_a, busy_a;
  logic       ready_b, ds_b, shcp_b, stcp_b, busy_b;
`ifdef HC595_OE_EN
  logic       oe_a, oe_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         latches_a = 0;

  hc595_tx #(.N(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .d(d_a), .valid(valid_a), .ready(ready_a),
    .DS(ds_a), .SHCP(shcp_a), .STCP(stcp_a), .busy(busy_a)
`ifdef HC595_OE_EN
    , .OE_n(oe_a)
`endif
  );

  hc595_tx #(.N(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .valid(valid_b), .ready(ready_b),
    .DS(ds_b), .SHCP(shcp_b), .STCP(stcp_b), .busy(busy_b)
`ifdef HC595_OE_EN
    , .OE_n(oe_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: collect DS at SHCP rises, compare words on STCP rise
  initial begin : mon_a
    logic       p_shcp, p_stcp, p_ready, p_ds, first_done;
    int         bits, low, stcp_hi;
    logic [7:0] word;
    p_shcp = 1'b0; p_stcp = 1'b0; p_ready = 1'b1; p_ds = 1'b0; first_done = 1'b0;
    bits = 0; low = 0; stcp_hi = 0; word = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        bits = 0; low = 0; stcp_hi = 0; word = 8'h00; first_done = 1'b0;
      end else begin
        check("shcp_stcp_excl_a", 32'(shcp_a && stcp_a), 0);
        check("busy_not_ready_a", 32'(busy_a), 32'(!ready_a));
        if (shcp_a && p_shcp) check("ds_stable_a", 32'(ds_a), 32'(p_ds));
        if (shcp_a && !p_shcp) begin
          word = {word[6:0], ds_a};
          bits++;
        end
        if (stcp_a) stcp_hi++;
        if (stcp_a && !p_stcp) begin
          latches_a++;
          check("bits_per_xfer_a", bits, 8);
          check("latch_expected_a", 32'(exp_a.size() > 0), 1);
          if (exp_a.size() > 0) check("word_a", 32'(word), 32'(exp_a.pop_front()));
`ifdef HC595_OE_EN
          check("oe_during_latch", 32'(oe_a), first_done ? 0 : 1);
`endif
          bits = 0;
        end
        if (!stcp_a && p_stcp) begin
          check("stcp_width_a", stcp_hi, 2);
          stcp_hi = 0;
`ifdef HC595_OE_EN
          check("oe_after_latch", 32'(oe_a), 0);
`endif
          first_done = 1'b1;
        end
        if (!ready_a) low++;
        if (ready_a && !p_ready) begin
          check("ready_low_a", low, 34);
          low = 0;
        end
      end
      p_shcp = shcp_a; p_stcp = stcp_a; p_ready = ready_a; p_ds = ds_a;
    end
  end

  // Monitor B: same scoreboard for the CLK_DIV=1 instance
  initial begin : mon_b
    logic       p_shcp, p_stcp, p_ready;
    int         bits, low;
    logic [7:0] word;
    p_shcp = 1'b0; p_stcp = 1'b0; p_ready = 1'b1;
    bits = 0; low = 0; word = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        bits = 0; low = 0; word = 8'h00;
      end else begin
        check("shcp_stcp_excl_b", 32'(shcp_b && stcp_b), 0);
        check("busy_not_ready_b", 32'(busy_b), 32'(!ready_b));
        if (shcp_b && !p_shcp) begin
          word = {word[6:0], ds_b};
          bits++;
        end
        if (stcp_b && !p_stcp) begin
          check("bits_per_xfer_b", bits, 8);
          check("latch_expected_b", 32'(exp_b.size() > 0), 1);
          if (exp_b.size() > 0) check("word_b", 32'(word), 32'(exp_b.pop_front()));
          bits = 0;
        end
        if (!ready_b) low++;
        if (ready_b && !p_ready) begin
          check("ready_low_b", low, 17);
          low = 0;
        end
      end
      p_shcp = shcp_b; p_stcp = stcp_b; p_ready = ready_b;
    end
  end

  task automatic send_a(input logic [7:0] w, input bit expect_latch);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_a && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("send_wait_a", 32'(t < 500), 1);
    d_a = w;
    valid_a = 1'b1;
    if (expect_latch) exp_a.push_back(w);
    @(negedge clk);
    valid_a = 1'b0;
    d_a = 8'h5A;
  endtask

  task automatic wait_idle_a();
    int t;
    t = 0;
    while ((exp_a.size() != 0 || !ready_a) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout_a", 32'(t < 2000), 1);
  endtask

  initial begin : stim
    int t, rises, gap, latch_snap;
    logic prev;
    rst = 1'b1; d_a = 8'h00; d_b = 8'h00; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_a), 1);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ds", 32'(ds_a), 0);
    check("rst_shcp", 32'(shcp_a), 0);
    check("rst_stcp", 32'(stcp_a), 0);
`ifdef HC595_OE_EN
    check("rst_oe", 32'(oe_a), 1);
`endif

    // First accept on the first posedge after reset release
    rst = 1'b0;
    d_a = 8'hA5;
    valid_a = 1'b1;
    exp_a.push_back(8'hA5);
    @(posedge clk);
    #1;
    check("first_accept", 32'(ready_a), 0);
    @(negedge clk);
    valid_a = 1'b0;
    wait_idle_a();

    send_a(8'h01, 1'b1);
    wait_idle_a();

    // Mid-transfer d change and valid pulse must be ignored
    send_a(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    d_a = 8'hFF;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    wait_idle_a();
    repeat (5) @(negedge clk);
    check("no_spurious_accept", 32'(ready_a), 1);

    // Reset after the 4th SHCP rise aborts with no latch
    send_a(8'hC3, 1'b0);
    rises = 0; t = 0; prev = shcp_a;
    while (rises < 4 && t < 500) begin
      @(negedge clk);
      if (shcp_a && !prev) rises++;
      prev = shcp_a;
      t++;
    end
    check("abort_wait", rises, 4);
    latch_snap = latches_a;
    #2 rst = 1'b1;
    #1;
    check("abort_ds", 32'(ds_a), 0);
    check("abort_shcp", 32'(shcp_a), 0);
    check("abort_stcp", 32'(stcp_a), 0);
    check("abort_ready", 32'(ready_a), 1);
    check("abort_busy", 32'(busy_a), 0);
`ifdef HC595_OE_EN
    check("abort_oe", 32'(oe_a), 1);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_latch_on_abort", latches_a, latch_snap);
    send_a(8'h81, 1'b1);
    wait_idle_a();

    // Back-to-back on the CLK_DIV=1 instance with valid held
    @(negedge clk);
    d_b = 8'hFF;
    valid_b = 1'b1;
    exp_b.push_back(8'hFF);
    exp_b.push_back(8'h00);
    t = 0;
    while (ready_b && t < 50) begin
      @(negedge clk);
      t++;
    end
    d_b = 8'h00;
    t = 0;
    while (!ready_b && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_done", 32'(ready_b), 1);
    gap = 0;
    while (ready_b && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_idle_gap", gap, 1);
    valid_b = 1'b0;
    t = 0;
    while ((exp_b.size() != 0 || !ready_b) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout_b", 32'(t < 200), 1);
    repeat (5) @(negedge clk);
    check("b2b_no_third", 32'(ready_b), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
